// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: upstream controller for one RW port of a 16x256 data SRAM.
//   Zero-fills the array after reset, then turns a valid/ready request
//   stream into SRAM pins and returns read data in order through a small FIFO.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake (req_ready is combinational)
//   req_we/addr/wmask/wdata         request fields
//   resp_valid/resp_ready/rdata     in-order read response stream
//   init_done                       high once zero-fill is complete
//   sram_csb/web/wmask/addr/din     SRAM pin drive (combinational)
//   sram_dout                       SRAM read data, valid the cycle after accept
module sram_port_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned NUM_WMASKS = 32,
  parameter int unsigned RESP_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  init_done,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [NUM_WMASKS-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W     = $clog2(RESP_DEPTH + 1);
  localparam int unsigned OCC_W     = CNT_W + 1;
  localparam int unsigned PTR_W     = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  rd_pending_q, rd_pending_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [RESP_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_mem_d [RESP_DEPTH];

  logic             push;
  logic             pop;
  logic             accept;
  logic [OCC_W-1:0] occ_after_pop;

  // Pointer advance modulo RESP_DEPTH (depth need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RESP_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Handshake: ready counts the read still in flight so the FIFO can never overflow.
  always_comb begin
    pop           = (count_q != '0) && resp_ready;
    push          = rd_pending_q;
    occ_after_pop = OCC_W'(count_q) + OCC_W'(rd_pending_q) - OCC_W'(pop);
    req_ready     = (state_q == ST_RUN) && (occ_after_pop < OCC_W'(RESP_DEPTH));
    accept        = req_valid && req_ready;
    resp_valid    = (count_q != '0);
    resp_rdata    = fifo_mem_q[rd_ptr_q];
    init_done     = (state_q == ST_RUN);
  end

  // Next state: zero-fill sweep, then run.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        if (init_cnt_q == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // SRAM pin drive; rst_n gating holds pins idle while reset is asserted.
  always_comb begin
    sram_csb   = 1'b1;
    sram_web   = 1'b1;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    if (rst_n) begin
      if (state_q == ST_INIT) begin
        sram_csb   = 1'b0;
        sram_web   = 1'b0;
        sram_wmask = '1;
        sram_addr  = init_cnt_q;
      end else if (accept) begin
        sram_csb   = 1'b0;
        sram_web   = ~req_we;
        sram_wmask = req_wmask;
        sram_addr  = req_addr;
        sram_din   = req_wdata;
      end
    end
  end

  // Response FIFO: read data lands one cycle after its accept edge.
  always_comb begin
    rd_pending_d = accept && !req_we;
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_mem_d   = fifo_mem_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = sram_dout;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      rd_pending_q <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_mem_q   <= '{default: '0};
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      rd_pending_q <= rd_pending_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_mem_q   <= fifo_mem_d;
    end
  end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb_sram_port_ctrl: scoreboard bench for sram_port_ctrl with a behavioural
//   16x256 SRAM (registered address, combinational dout, byte masks).
module tb_sram_port_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 256;
  localparam int unsigned MW = 32;
  localparam int unsigned RD = 2;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [MW-1:0] req_wmask;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          init_done;
  logic          sram_csb;
  logic          sram_web;
  logic [MW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;

  sram_port_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW), .RESP_DEPTH(RD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .init_done(init_done),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] mem_addr_r;
  initial begin
    mem_addr_r = '0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = {8{$urandom}};
  end
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) begin
        for (int b = 0; b < int'(MW); b++)
          if (sram_wmask[b]) mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
      end
      mem_addr_r <= sram_addr;
    end
  end
  assign sram_dout = mem[mem_addr_r];

  // Bookkeeping
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_n, acc_first, acc_last;
  int pop_n, pop_first, pop_last;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] sb_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, predicts what the next rising edge does.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (rst_n) begin
      if (resp_valid && resp_ready) begin
        if (sb_q.size() == 0) begin
          check("resp_unexpected", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("rdata", resp_rdata, e);
        end
        pop_n++;
        if (pop_n == 1) pop_first = cyc;
        pop_last = cyc;
      end
      if (req_valid && req_ready) begin
        if (req_we) begin
          for (int b = 0; b < int'(MW); b++)
            if (req_wmask[b]) ref_mem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
        end else begin
          sb_q.push_back(ref_mem[req_addr]);
        end
        acc_n++;
        if (acc_n == 1) acc_first = cyc;
        acc_last = cyc;
      end
      check("sb_depth", DW'(sb_q.size() <= int'(RD)), 1);
    end
  end

  task automatic check_rst_outs(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_init_done"}, init_done, 0);
    check({tag, "_csb"}, sram_csb, 1);
    check({tag, "_web"}, sram_web, 1);
    check({tag, "_wmask"}, sram_wmask, 0);
    check({tag, "_addr"}, sram_addr, 0);
    check({tag, "_din"}, sram_din, 0);
  endtask

  task automatic check_init_pins(input int a);
    check("init_csb", sram_csb, 0);
    check("init_web", sram_web, 0);
    check("init_wmask", sram_wmask, {MW{1'b1}});
    check("init_addr", sram_addr, DW'(a));
    check("init_din", sram_din, 0);
    check("init_ready", req_ready, 0);
    check("init_done_lo", init_done, 0);
  endtask

  task automatic assert_reset(input string tag);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check_rst_outs(tag);
  endtask

  // Release reset and follow INIT for stop_at further cycles (16 = full sweep).
  task automatic run_init(input int stop_at);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    #1;
    check_init_pins(0);
    for (int i = 1; i < int'(DEPTH) && i <= stop_at; i++) begin
      @(posedge clk); #1;
      check_init_pins(i);
    end
    if (stop_at >= int'(DEPTH)) begin
      @(posedge clk); #1;
      check("run_init_done", init_done, 1);
      check("run_req_ready", req_ready, 1);
    end
  endtask

  // Present one request and hold it until accepted; returns at accept edge + 1.
  task automatic send(input logic we, input logic [AW-1:0] a,
                      input logic [MW-1:0] m, input logic [DW-1:0] d);
    int waits;
    waits = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wmask = m; req_wdata = d;
    @(negedge clk);
    while (!req_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!req_ready) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int waits;
    waits = 0;
    while (sb_q.size() != 0 && waits < 50) begin
      waits++;
      @(posedge clk); #1;
    end
    check({tag, "_drained"}, DW'(sb_q.size()), 0);
  endtask

  initial begin
    logic [DW-1:0] a5;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wmask = '0; req_wdata = '0; resp_ready = 1'b1;
    acc_n = 0; pop_n = 0; acc_first = 0; acc_last = 0; pop_first = 0; pop_last = 0;
    #1;
    check_rst_outs("por");

    // 1: zero-fill sweep, then every line reads back 0
    run_init(DEPTH);
    for (int i = 0; i < int'(DEPTH); i++) send(1'b0, AW'(i), '0, '0);
    drain("t1");

    // 2: full write then read; response one cycle after the read accept edge
    a5 = {32{8'hA5}};
    send(1'b1, 4'd5, '1, a5);
    send(1'b0, 4'd5, '0, '0);
    check("t2_rv_early", resp_valid, 0);
    @(posedge clk); #1;
    check("t2_rv_late", resp_valid, 1);
    check("t2_rdata_const", resp_rdata, a5);
    drain("t2");

    // 3: byte-masked write changes only byte 0
    send(1'b1, 4'd5, 32'h0000_0001, DW'(8'hFF));
    send(1'b0, 4'd5, '0, '0);
    @(posedge clk); #1;
    check("t3_rdata_const", resp_rdata, {{31{8'hA5}}, 8'hFF});
    drain("t3");

    // 4: back-pressure with two slots, then ordered release
    send(1'b1, 4'd1, '1, {8{32'h1111_1111}});
    send(1'b1, 4'd2, '1, {8{32'h2222_2222}});
    send(1'b1, 4'd3, '1, {8{32'h3333_3333}});
    resp_ready = 1'b0;
    acc_n = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd1;
    @(negedge clk); check("t4_rdy1", req_ready, 1);
    @(posedge clk); #1; req_addr = 4'd2;
    @(negedge clk); check("t4_rdy2", req_ready, 1);
    @(posedge clk); #1; req_addr = 4'd3;
    @(negedge clk); check("t4_rdy3", req_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_rdy_stall", req_ready, 0);
    check("t4_rv", resp_valid, 1);
    check("t4_acc", DW'(acc_n), 2);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    #1;
    check("t4_rdy_pop", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain("t4");
    check("t4_acc_all", DW'(acc_n), 3);

    // 5: eight back-to-back reads stream at one per cycle
    acc_n = 0; pop_n = 0;
    for (int i = 0; i < 8; i++) send(1'b0, AW'(i), '0, '0);
    repeat (4) @(posedge clk);
    #1;
    check("t5_acc_n", DW'(acc_n), 8);
    check("t5_acc_span", DW'(acc_last - acc_first), 7);
    check("t5_pop_n", DW'(pop_n), 8);
    check("t5_pop_span", DW'(pop_last - pop_first), 7);
    check("t5_empty", DW'(sb_q.size()), 0);

    // 6: reset mid-INIT, and again with two responses queued
    @(posedge clk); #3;
    assert_reset("t6a");
    run_init(7);
    @(posedge clk); #3;
    assert_reset("t6b");
    run_init(DEPTH);
    resp_ready = 1'b0;
    send(1'b1, 4'd9, '1, {8{32'hDEAD_BEEF}});
    send(1'b0, 4'd9, '0, '0);
    send(1'b0, 4'd0, '0, '0);
    @(posedge clk); #1;
    check("t6_rv_full", resp_valid, 1);
    check("t6_rdy_full", req_ready, 0);
    #2;
    assert_reset("t6c");
    run_init(DEPTH);
    check("t6_rv_after", resp_valid, 0);
    resp_ready = 1'b1;
    send(1'b0, 4'd9, '0, '0);
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
